count_seq_monitor: RTL

//  Downstream checker for the 4-bit free-running state counter. It samples the counter

---
 rtl/count_seq_monitor_if.sv | 26 ++
 rtl/count_seq_monitor.sv | 108 ++++++++++
 2 files changed

// File: rtl/count_seq_monitor_if.sv
// Bus between an upstream counter source and the sequence monitor.
// The source side drives the sampled count and controls; the monitor returns status.
interface count_seq_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
);
  logic [WIDTH-1:0]  count_in;
  logic              sample;
  logic              clr;
  logic              locked;
  logic              wrap;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output count_in, sample, clr,
    input  locked, wrap, wrap_cnt, err, err_cnt
  );

  modport slave (
    input  count_in, sample, clr,
    output locked, wrap, wrap_cnt, err, err_cnt
  );
endinterface

// File: rtl/count_seq_monitor.sv
// Checks that each qualified sample of a free-running counter is the previous value
// plus one; locks after LOCK_LEN good increments, counts wraps and in-lock breaks.
module count_seq_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  count_seq_monitor_if.slave    bus
);
  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] LOCK_LEN_C = RUN_W'(LOCK_LEN);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  prev_q;
  logic [RUN_W-1:0]  run_q;
  logic              locked_q;
  logic              wrap_q;
  logic [WRAP_W-1:0] wrap_cnt_q;
  logic              err_q;
  logic [ERR_W-1:0]  err_cnt_q;

  logic [WIDTH-1:0]  prev_inc_d;
  logic [RUN_W-1:0]  run_inc_d;
  logic              match_d;
  logic              wrap_d;
  logic              brk_d;

  always_comb begin
    prev_inc_d = prev_q + 1'b1;
    run_inc_d  = run_q + 1'b1;
    match_d    = (bus.count_in == prev_inc_d);
    // A wrap is only credited once a previous value has been captured.
    wrap_d     = bus.sample && (state_q != IDLE) && (prev_q == '1) && (bus.count_in == '0);
    brk_d      = bus.sample && (state_q == LOCKED) && !match_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      run_q      <= '0;
      locked_q   <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wrap_q <= wrap_d;
      if (bus.sample) begin
        prev_q <= bus.count_in;
        unique case (state_q)
          IDLE: begin
            run_q    <= '0;
            state_q  <= ACQUIRE;
            locked_q <= 1'b0;
          end
          ACQUIRE: begin
            if (!match_d) begin
              run_q <= '0;
            end else if (run_inc_d == LOCK_LEN_C) begin
              run_q    <= '0;
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              run_q <= run_inc_d;
            end
          end
          LOCKED: begin
            if (!match_d) begin
              run_q    <= '0;
              state_q  <= ACQUIRE;
              locked_q <= 1'b0;
            end
          end
          default: begin
            run_q    <= '0;
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end

      // clr wins over any counter update landing on the same edge.
      if (bus.clr) begin
        wrap_cnt_q <= '0;
        err_q      <= 1'b0;
        err_cnt_q  <= '0;
      end else begin
        if (wrap_d) wrap_cnt_q <= wrap_cnt_q + 1'b1;
        if (brk_d) begin
          err_q <= 1'b1;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.locked   = locked_q;
  assign bus.wrap     = wrap_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;
endmodule
